// File: rtl/topcpu_pkg.sv
// Shared TopCPU definitions: instruction layout, NOP encoding and the boot image
// that the fetch-stage memory loads on reset.
package topcpu_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

    // Instruction field positions
    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 28;
    localparam int RD_HI     = 27;
    localparam int RD_LO     = 23;
    localparam int RS_HI     = 22;
    localparam int RS_LO     = 18;
    localparam int RT_HI     = 17;
    localparam int RT_LO     = 13;
    localparam int IMM_HI    = 12;
    localparam int IMM_LO    = 0;

    localparam int BOOT_LEN = 6;

    // Entry [0] is the lowest word of the packed array, so word 0 sits rightmost.
    localparam logic [BOOT_LEN-1:0][INSTR_W-1:0] BOOT_IMAGE = {
        32'h3F64_A000,
        32'h5280_0002,
        32'h6A64_0005,
        32'h1CA9_E000,
        32'h5780_000F,
        32'h5500_000A
    };

    // Reset contents of word idx: boot image first, NOP everywhere else.
    function automatic logic [INSTR_W-1:0] boot_word(input int idx);
        logic [INSTR_W-1:0] word;
        word = NOP;
        for (int k = 0; k < BOOT_LEN; k++) begin
            if (k == idx) begin
                word = BOOT_IMAGE[k];
            end
        end
        return word;
    endfunction

endpackage

// File: rtl/instr_mem_sync.sv
// Synchronous-read instruction memory for the TopCPU fetch stage, with a
// stall-aware registered output and a program-load write port.
module instr_mem_sync
    import topcpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] pc,
    input  logic              stall,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_valid,
    output logic              addr_fault,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data
);

    // One extra bit so DEPTH == 2**ADDR_W is representable and never faults.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic fetch_in_range;
    logic prog_in_range;
    logic fetch_take;

    assign fetch_in_range = ({1'b0, pc} < DEPTH_L);
    assign prog_in_range  = ({1'b0, prog_addr} < DEPTH_L);
    assign fetch_take     = fetch_req && !stall && !prog_we;

    // NOTE: the array is deliberately reset so the boot image is present with
    // no loader; this rules out block-RAM mapping, which is accepted here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DATA_W'(boot_word(i));
            end
        end else if (prog_we && prog_in_range) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // NOTE: non-blocking assignments here mean a write and a read of the same
    // word at one edge cannot see each other; write-priority makes that moot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instruction <= '0;
            instr_valid <= 1'b0;
        end else if (stall) begin
            instruction <= instruction;
            instr_valid <= instr_valid;
        end else if (prog_we) begin
            instr_valid <= 1'b0;
        end else if (fetch_req) begin
            instr_valid <= 1'b1;
            instruction <= fetch_in_range ? mem[pc] : DATA_W'(NOP);
        end else begin
            instr_valid <= 1'b0;
        end
    end

    // Writes fault regardless of stall; fetches fault only when actually captured.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_fault <= 1'b0;
        end else begin
            addr_fault <= (prog_we && !prog_in_range) || (fetch_take && !fetch_in_range);
        end
    end

endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed self-checking bench for instr_mem_sync (DEPTH=24 so out-of-range
// addresses exist); outputs are sampled 1 time unit after each rising edge.
module tb_instr_mem_sync;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 24;

    logic              clk;
    logic              reset;
    logic              fetch_req;
    logic [ADDR_W-1:0] pc;
    logic              stall;
    logic [DATA_W-1:0] instruction;
    logic              instr_valid;
    logic              addr_fault;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;

    int total;
    int bad;

    logic [31:0] boot_exp [7] = '{
        32'h5500_000A, 32'h5780_000F, 32'h1CA9_E000, 32'h6A64_0005,
        32'h5280_0002, 32'h3F64_A000, 32'h0000_0000
    };

    instr_mem_sync #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_req  (fetch_req),
        .pc         (pc),
        .stall      (stall),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .addr_fault (addr_fault),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fetch_req = 1'b0;
        stall     = 1'b0;
        prog_we   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        pc        = '0;
        prog_addr = '0;
        prog_data = '0;
        tick();
        total++;
        if (instruction !== 32'h0) begin
            bad++;
            $display("FAIL reset_instr got=%h want=%h", instruction, 32'h0);
        end
        total++;
        if (instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid got=%b want=0", instr_valid);
        end
        total++;
        if (addr_fault !== 1'b0) begin
            bad++;
            $display("FAIL reset_fault got=%b want=0", addr_fault);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_boot_image();
        for (int i = 0; i < 7; i++) begin
            fetch_req = 1'b1;
            pc        = ADDR_W'(i);
            tick();
            total++;
            if (instruction !== boot_exp[i] || instr_valid !== 1'b1 || addr_fault !== 1'b0) begin
                bad++;
                $display("FAIL boot_word%0d got=%h/v%b/f%b want=%h/v1/f0",
                         i, instruction, instr_valid, addr_fault, boot_exp[i]);
            end
        end
        idle();
        tick();
        total++;
        if (instr_valid !== 1'b0 || instruction !== 32'h0) begin
            bad++;
            $display("FAIL boot_idle got=%h/v%b want=00000000/v0", instruction, instr_valid);
        end
    endtask

    task automatic test_stall_hold();
        fetch_req = 1'b1;
        pc        = 5'd2;
        tick();
        total++;
        if (instruction !== 32'h1CA9_E000 || instr_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall_pre got=%h/v%b want=1ca9e000/v1", instruction, instr_valid);
        end
        stall = 1'b1;
        pc    = 5'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (instruction !== 32'h1CA9_E000 || instr_valid !== 1'b1) begin
                bad++;
                $display("FAIL stall_hold%0d got=%h/v%b want=1ca9e000/v1", i, instruction, instr_valid);
            end
        end
        stall = 1'b0;
        tick();
        total++;
        if (instruction !== 32'h5280_0002 || instr_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall_release got=%h/v%b want=52800002/v1", instruction, instr_valid);
        end
        idle();
        tick();
    endtask

    task automatic test_write_read();
        prog_we   = 1'b1;
        prog_addr = 5'd7;
        prog_data = 32'hDEAD_BEEF;
        fetch_req = 1'b1;
        pc        = 5'd0;
        tick();
        total++;
        if (instr_valid !== 1'b0 || instruction !== 32'h5280_0002 || addr_fault !== 1'b0) begin
            bad++;
            $display("FAIL wr_priority got=%h/v%b/f%b want=52800002/v0/f0",
                     instruction, instr_valid, addr_fault);
        end
        prog_we = 1'b0;
        pc      = 5'd7;
        tick();
        total++;
        if (instruction !== 32'hDEAD_BEEF || instr_valid !== 1'b1) begin
            bad++;
            $display("FAIL wr_readback got=%h/v%b want=deadbeef/v1", instruction, instr_valid);
        end
        idle();
        tick();
    endtask

    task automatic test_out_of_range();
        fetch_req = 1'b1;
        pc        = 5'd25;
        tick();
        total++;
        if (instruction !== 32'h0 || instr_valid !== 1'b1 || addr_fault !== 1'b1) begin
            bad++;
            $display("FAIL oor_fetch got=%h/v%b/f%b want=00000000/v1/f1",
                     instruction, instr_valid, addr_fault);
        end
        idle();
        tick();
        total++;
        if (addr_fault !== 1'b0 || instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL oor_pulse_end got=f%b/v%b want=f0/v0", addr_fault, instr_valid);
        end
        prog_we   = 1'b1;
        prog_addr = 5'd30;
        prog_data = 32'hCAFE_F00D;
        tick();
        total++;
        if (addr_fault !== 1'b1) begin
            bad++;
            $display("FAIL oor_write_fault got=%b want=1", addr_fault);
        end
        prog_we = 1'b0;
        tick();
        total++;
        if (addr_fault !== 1'b0) begin
            bad++;
            $display("FAIL oor_write_pulse_end got=%b want=0", addr_fault);
        end
        fetch_req = 1'b1;
        pc        = 5'd30;
        tick();
        total++;
        if (instruction !== 32'h0 || addr_fault !== 1'b1) begin
            bad++;
            $display("FAIL oor_write_dropped got=%h/f%b want=00000000/f1", instruction, addr_fault);
        end
        // Last implemented word is writable, readable and never faults.
        fetch_req = 1'b0;
        prog_we   = 1'b1;
        prog_addr = 5'd23;
        prog_data = 32'hA5A5_A5A5;
        tick();
        total++;
        if (addr_fault !== 1'b0) begin
            bad++;
            $display("FAIL edge_write_fault got=%b want=0", addr_fault);
        end
        prog_we   = 1'b0;
        fetch_req = 1'b1;
        pc        = 5'd23;
        tick();
        total++;
        if (instruction !== 32'hA5A5_A5A5 || addr_fault !== 1'b0 || instr_valid !== 1'b1) begin
            bad++;
            $display("FAIL edge_read got=%h/v%b/f%b want=a5a5a5a5/v1/f0",
                     instruction, instr_valid, addr_fault);
        end
        pc = 5'd24;
        tick();
        total++;
        if (instruction !== 32'h0 || addr_fault !== 1'b1) begin
            bad++;
            $display("FAIL edge_depth got=%h/f%b want=00000000/f1", instruction, addr_fault);
        end
        idle();
        tick();
    endtask

    task automatic test_write_during_stall();
        fetch_req = 1'b1;
        pc        = 5'd1;
        tick();
        fetch_req = 1'b0;
        stall     = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 5'd3;
        prog_data = 32'h1234_5678;
        tick();
        total++;
        if (instruction !== 32'h5780_000F || instr_valid !== 1'b1) begin
            bad++;
            $display("FAIL stallwr_hold got=%h/v%b want=5780000f/v1", instruction, instr_valid);
        end
        prog_we = 1'b0;
        tick();
        total++;
        if (instruction !== 32'h5780_000F || instr_valid !== 1'b1) begin
            bad++;
            $display("FAIL stallwr_hold2 got=%h/v%b want=5780000f/v1", instruction, instr_valid);
        end
        stall     = 1'b0;
        fetch_req = 1'b1;
        pc        = 5'd3;
        tick();
        total++;
        if (instruction !== 32'h1234_5678 || instr_valid !== 1'b1) begin
            bad++;
            $display("FAIL stallwr_read got=%h/v%b want=12345678/v1", instruction, instr_valid);
        end
        idle();
        tick();
    endtask

    task automatic test_reset_mid_run();
        prog_we   = 1'b1;
        prog_addr = 5'd0;
        prog_data = 32'hFFFF_0000;
        tick();
        prog_we   = 1'b0;
        fetch_req = 1'b1;
        pc        = 5'd0;
        tick();
        total++;
        if (instruction !== 32'hFFFF_0000 || instr_valid !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre got=%h/v%b want=ffff0000/v1", instruction, instr_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (instr_valid !== 1'b0 || instruction !== 32'h0) begin
            bad++;
            $display("FAIL rst_async got=%h/v%b want=00000000/v0", instruction, instr_valid);
        end
        tick();
        reset = 1'b0;
        pc    = 5'd0;
        tick();
        total++;
        if (instruction !== 32'h5500_000A || instr_valid !== 1'b1) begin
            bad++;
            $display("FAIL rst_word0 got=%h/v%b want=5500000a/v1", instruction, instr_valid);
        end
        pc = 5'd3;
        tick();
        total++;
        if (instruction !== 32'h6A64_0005) begin
            bad++;
            $display("FAIL rst_word3 got=%h want=6a640005", instruction);
        end
        pc = 5'd7;
        tick();
        total++;
        if (instruction !== 32'h0) begin
            bad++;
            $display("FAIL rst_word7 got=%h want=00000000", instruction);
        end
        idle();
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_boot_image();
        test_stall_hold();
        test_write_read();
        test_out_of_range();
        test_write_during_stall();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
